// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone bus-ownership scheduler.
package wb_pkg;

    localparam int WB_MAX_MASTERS = 8;

    typedef enum logic [1:0] {
        GS_IDLE = 2'd0,
        GS_OWN  = 2'd1,
        GS_REL  = 2'd2,
        GS_TERM = 2'd3
    } gs_state_e;

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational masked priority encoder: round-robin search from ptr with wrap,
// or fixed priority (lowest index) when mode=1.
module wb_rr_pick #(
    parameter int NM = 2,
    parameter int IW = 1
) (
    input  logic [NM-1:0] req,
    input  logic [IW-1:0] ptr,
    input  logic          mode,
    output logic [NM-1:0] onehot,
    output logic [IW-1:0] idx
);

    always_comb begin
        int  j;
        logic found;
        j      = 0;
        found  = 1'b0;
        onehot = '0;
        idx    = '0;
        for (int i = 0; i < NM; i++) begin
            j = mode ? i : (int'(ptr) + i) % NM;
            if (!found && req[j]) begin
                found     = 1'b1;
                onehot[j] = 1'b1;
                idx       = IW'(j);
            end
        end
    end

endmodule

// File: rtl/wb_grant_sched.sv
// Wishbone bus-ownership scheduler: round-robin / fixed-priority grant held for a whole cycle.
// Optional hung-cycle watchdog enabled with macro WB_GRANT_WATCHDOG_EN.
module wb_grant_sched
    import wb_pkg::*;
#(
    parameter int NM     = 2,
    parameter int IW     = (NM > 1) ? $clog2(NM) : 1,
    parameter int TO_CYC = 255
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_mode,
    input  logic [NM-1:0] i_cyc,
    input  logic [NM-1:0] i_stb,
    input  logic          i_ack,
    input  logic          i_err,
    input  logic          i_rty,
    output logic [NM-1:0] o_grant,
    output logic [IW-1:0] o_gidx,
    output logic          o_busy,
    output logic [NM-1:0] o_to_err
);

    gs_state_e     state;
    logic [IW-1:0] rr_ptr;
    logic [NM-1:0] pick_onehot;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] next_ptr;
    logic          owner_cyc;

    wb_rr_pick #(
        .NM(NM),
        .IW(IW)
    ) u_pick (
        .req   (i_cyc),
        .ptr   (rr_ptr),
        .mode  (i_mode),
        .onehot(pick_onehot),
        .idx   (pick_idx)
    );

    assign next_ptr  = (pick_idx == IW'(NM - 1)) ? '0 : pick_idx + 1'b1;
    assign owner_cyc = i_cyc[o_gidx];

`ifdef WB_GRANT_WATCHDOG_EN
    localparam logic [15:0] TO_LIM = 16'(TO_CYC);

    logic [15:0] wd_cnt;
    logic        wd_fire;

    // Counts consecutive stalled strobe cycles of the current owner.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wd_cnt <= '0;
        end else if (state != GS_OWN || i_ack || i_err || i_rty || !i_stb[o_gidx]) begin
            wd_cnt <= '0;
        end else if (wd_cnt < TO_LIM) begin
            wd_cnt <= wd_cnt + 16'd1;
        end
    end

    assign wd_fire = (wd_cnt == TO_LIM);
`else
    logic unused_wd;
    assign unused_wd = ^{i_stb, i_ack, i_err, i_rty};
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state    <= GS_IDLE;
            o_grant  <= '0;
            o_gidx   <= '0;
            o_busy   <= 1'b0;
            o_to_err <= '0;
            rr_ptr   <= '0;
        end else begin
            o_to_err <= '0;
            case (state)
                // REL is the single dead cycle; its closing edge is also an arbitration point,
                // so consecutive owners are separated by exactly one grant-free cycle.
                GS_IDLE, GS_REL: begin
                    if (|i_cyc) begin
                        state   <= GS_OWN;
                        o_grant <= pick_onehot;
                        o_gidx  <= pick_idx;
                        o_busy  <= 1'b1;
                        rr_ptr  <= next_ptr;
                    end else begin
                        state <= GS_IDLE;
                    end
                end
                GS_OWN: begin
                    if (!owner_cyc) begin
                        state   <= GS_REL;
                        o_grant <= '0;
                        o_busy  <= 1'b0;
                    end
`ifdef WB_GRANT_WATCHDOG_EN
                    else if (wd_fire) begin
                        state    <= GS_TERM;
                        o_to_err <= o_grant;
                    end
`endif
                end
`ifdef WB_GRANT_WATCHDOG_EN
                GS_TERM: begin
                    if (!owner_cyc) begin
                        state   <= GS_REL;
                        o_grant <= '0;
                        o_busy  <= 1'b0;
                    end
                end
`endif
                default: begin
                    state   <= GS_IDLE;
                    o_grant <= '0;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_grant_sched.sv
// Bench for wb_grant_sched: behavioural ownership model checked every cycle plus directed literals.
module tb_wb_grant_sched;

    localparam int NM     = 2;
    localparam int IW     = 1;
    localparam int TO_CYC = 4;
`ifdef WB_GRANT_WATCHDOG_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          mode  = 1'b0;
    logic [NM-1:0] cyc   = '0;
    logic [NM-1:0] stb   = '0;
    logic          ack   = 1'b0;
    logic          err   = 1'b0;
    logic          rty   = 1'b0;
    logic [NM-1:0] grant;
    logic [IW-1:0] gidx;
    logic          busy;
    logic [NM-1:0] to_err;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    wb_grant_sched #(
        .NM    (NM),
        .IW    (IW),
        .TO_CYC(TO_CYC)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst_n),
        .i_mode  (mode),
        .i_cyc   (cyc),
        .i_stb   (stb),
        .i_ack   (ack),
        .i_err   (err),
        .i_rty   (rty),
        .o_grant (grant),
        .o_gidx  (gidx),
        .o_busy  (busy),
        .o_to_err(to_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Behavioural model: who owns the bus, the rotation pointer and the stall count.
    typedef enum int {M_IDLE, M_OWN, M_GAP, M_TERM} mphase_e;
    mphase_e m_ph    = M_IDLE;
    int      m_last  = 0;
    int      m_ptr   = 0;
    int      m_stall = 0;
    bit      m_pulse = 1'b0;

    function automatic int pick(input logic [NM-1:0] req, input logic prio, input int ptr);
        int s;
        s = prio ? 0 : ptr;
        for (int k = 0; k < NM; k++) begin
            if (req[(s + k) % NM]) return (s + k) % NM;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        mphase_e was;
        int      w;
        if (!rst_n) begin
            m_ph    = M_IDLE;
            m_last  = 0;
            m_ptr   = 0;
            m_stall = 0;
            m_pulse = 1'b0;
        end else begin
            was     = m_ph;
            m_pulse = 1'b0;
            case (was)
                M_IDLE, M_GAP: begin
                    w = pick(cyc, mode, m_ptr);
                    if (w >= 0) begin
                        m_last = w;
                        m_ptr  = (w + 1) % NM;
                        m_ph   = M_OWN;
                    end else begin
                        m_ph = M_IDLE;
                    end
                end
                M_OWN: begin
                    if (!cyc[m_last]) m_ph = M_GAP;
                    else if (WD_ON && m_stall == TO_CYC) begin
                        m_ph    = M_TERM;
                        m_pulse = 1'b1;
                    end
                end
                M_TERM: if (!cyc[m_last]) m_ph = M_GAP;
                default: m_ph = M_IDLE;
            endcase
            if (was == M_OWN && stb[m_last] && !(ack || err || rty))
                m_stall = (m_stall < TO_CYC) ? m_stall + 1 : m_stall;
            else
                m_stall = 0;
        end
    end

    always @(negedge clk) begin
        bit owned;
        owned = (m_ph == M_OWN || m_ph == M_TERM);
        chk("grant", 32'(grant), owned ? 32'(1 << m_last) : 32'd0);
        chk("gidx", 32'(gidx), 32'(m_last));
        chk("busy", 32'(busy), 32'(owned));
        chk("to_err", 32'(to_err), m_pulse ? 32'(1 << m_last) : 32'd0);
        chk("onehot", 32'($countones(grant) <= 1), 32'd1);
    end

    initial begin
        #1 rst_n = 1'b0;
        tick(2);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_gidx", 32'(gidx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_to_err", 32'(to_err), 32'd0);
        rst_n = 1'b1;
        tick(1);
        chk("idle_grant", 32'(grant), 32'd0);

        // Round-robin alternation with both masters requesting.
        mode = 1'b0;
        cyc  = 2'b11;
        tick(1);
        chk("t1_g0", 32'(grant), 32'h1);
        tick(2);
        cyc = 2'b10;
        tick(1);
        chk("t1_g1", 32'(grant), 32'h0);
        cyc = 2'b11;
        tick(1);
        chk("t1_g2", 32'(grant), 32'h2);
        chk("t1_gidx", 32'(gidx), 32'd1);
        tick(2);
        cyc = 2'b01;
        tick(1);
        chk("t1_g3", 32'(grant), 32'h0);
        cyc = 2'b11;
        tick(1);
        chk("t1_g4", 32'(grant), 32'h1);

        // Fixed priority: master 0 re-requests in the dead cycle and wins again.
        mode = 1'b1;
        tick(2);
        cyc = 2'b10;
        tick(1);
        chk("t2_rel", 32'(grant), 32'h0);
        cyc = 2'b11;
        tick(1);
        chk("t2_regrant", 32'(grant), 32'h1);
        tick(1);
        cyc = 2'b10;
        tick(1);
        cyc = 2'b11;
        tick(1);
        chk("t2_starve", 32'(grant), 32'h1);

        // No preemption: master 0 waits for master 1 to finish.
        cyc  = 2'b00;
        mode = 1'b0;
        tick(3);
        cyc = 2'b10;
        tick(1);
        chk("t3_own1", 32'(grant), 32'h2);
        cyc = 2'b11;
        tick(1);
        chk("t3_hold_a", 32'(grant), 32'h2);
        tick(2);
        chk("t3_hold_b", 32'(grant), 32'h2);
        cyc = 2'b01;
        tick(1);
        chk("t3_gap", 32'(grant), 32'h0);
        tick(1);
        chk("t3_next", 32'(grant), 32'h1);

        // Asynchronous reset between edges while owned; pointer restarts at 0.
        cyc = 2'b11;
        tick(1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_grant", 32'(grant), 32'h0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_to_err", 32'(to_err), 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("t6_first", 32'(grant), 32'h1);
        cyc = 2'b00;
        tick(3);

`ifdef WB_GRANT_WATCHDOG_EN
        // Stalled strobe trips the watchdog; grant holds until CYC drops.
        cyc = 2'b01;
        stb = 2'b01;
        tick(1);
        chk("t4_grant", 32'(grant), 32'h1);
        tick(4);
        chk("t4_pre", 32'(to_err), 32'h0);
        tick(1);
        chk("t4_pulse", 32'(to_err), 32'h1);
        chk("t4_pulse_grant", 32'(grant), 32'h1);
        tick(1);
        chk("t4_after", 32'(to_err), 32'h0);
        chk("t4_held", 32'(grant), 32'h1);
        cyc = 2'b00;
        stb = 2'b00;
        tick(1);
        chk("t4_rel", 32'(grant), 32'h0);
        tick(2);

        // Owner drops CYC during the pulse cycle.
        cyc = 2'b10;
        stb = 2'b10;
        tick(1);
        chk("t4b_grant", 32'(grant), 32'h2);
        tick(5);
        chk("t4b_pulse", 32'(to_err), 32'h2);
        cyc = 2'b00;
        stb = 2'b00;
        tick(1);
        chk("t4b_rel", 32'(grant), 32'h0);
        tick(2);

        // ACK on the fourth stalled cycle clears the count: no pulse.
        cyc = 2'b01;
        stb = 2'b01;
        tick(1);
        tick(3);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        stb = 2'b00;
        tick(1);
        chk("t5_nopulse", 32'(to_err), 32'h0);
        tick(3);
        chk("t5_held", 32'(grant), 32'h1);
        cyc = 2'b00;
        tick(2);
`else
        // Without the watchdog a hung slave keeps the bus owned.
        cyc = 2'b01;
        stb = 2'b01;
        tick(1);
        chk("hung_grant", 32'(grant), 32'h1);
        tick(10);
        chk("hung_held", 32'(grant), 32'h1);
        chk("hung_to_err", 32'(to_err), 32'h0);
        cyc = 2'b00;
        stb = 2'b00;
        tick(2);
`endif

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
